// File: rtl/pcint_ctrl.sv
// -----------------------------------------------------------------------------
// pcint_ctrl -- pin-change interrupt controller for PCINT[27:0]
//
// Takes the raw pin values from the four port blocks, synchronises them, detects
// edges on the masked pins, and sets one flag per group of eight pins (PCIF0..3).
// It raises one interrupt request per group when that group is enabled in PCICR.
// It owns PCICR, PCIFR and PCMSK0..3. It returns the mask and group-enable bits
// to the port blocks, which use them for digital-input-enable override.
//
// Ports
//   cp2, ireset         clock (rising edge) / asynchronous active-low reset
//   IO_Addr, iore, iowe I/O-space bus (PCIFR only)
//   ramadr, ramre, ramwe data-space bus (PCICR, PCMSK0..3)
//   dbus_in / dbus_out  write data / read data (0 when not selected)
//   out_en              high while this block drives dbus_out
//   pcint_pin[27:0]     asynchronous pin values
//   pcmsk[27:0]         {PCMSK3[3:0], PCMSK2, PCMSK1[7:0], PCMSK0}, unimplemented bits 0
//   pcie[3:0]           PCICR[3:0]
//   irq[3:0]            per-group interrupt request
//   irq_ack[3:0]        one-cycle vector-taken acknowledge per group
// -----------------------------------------------------------------------------
module pcint_ctrl #(
  parameter logic [5:0] PCIFR_IO_ADDR   = 6'h1B,
  parameter logic [7:0] PCICR_RAM_ADDR  = 8'h68,
  parameter logic [7:0] PCMSK0_RAM_ADDR = 8'h6B,
  parameter logic [7:0] PCMSK1_RAM_ADDR = 8'h6C,
  parameter logic [7:0] PCMSK2_RAM_ADDR = 8'h6D,
  parameter logic [7:0] PCMSK3_RAM_ADDR = 8'h73
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic [5:0]  IO_Addr,
  input  logic        iore,
  input  logic        iowe,
  input  logic [7:0]  ramadr,
  input  logic        ramre,
  input  logic        ramwe,
  input  logic [7:0]  dbus_in,
  output logic [7:0]  dbus_out,
  output logic        out_en,
  input  logic [27:0] pcint_pin,
  output logic [27:0] pcmsk,
  output logic [3:0]  pcie,
  output logic [3:0]  irq,
  input  logic [3:0]  irq_ack
);

  // Register storage. Only implemented bits are stored, so unimplemented
  // bits cannot be set by any write.
  logic [3:0]  pcicr_q;
  logic [3:0]  pcifr_q;
  logic [7:0]  pcmsk0_q;
  logic [6:0]  pcmsk1_q;
  logic [7:0]  pcmsk2_q;
  logic [3:0]  pcmsk3_q;

  // Two-flop synchroniser, followed by the history register for edge detection.
  logic [27:0] sync1_q;
  logic [27:0] sync2_q;
  logic [27:0] hist_q;

  // Bus decode.
  logic pcifr_io_hit;
  logic pcicr_hit;
  logic pcmsk0_hit;
  logic pcmsk1_hit;
  logic pcmsk2_hit;
  logic pcmsk3_hit;
  logic ram_hit;

  assign pcifr_io_hit = (IO_Addr == PCIFR_IO_ADDR);
  assign pcicr_hit    = (ramadr == PCICR_RAM_ADDR);
  assign pcmsk0_hit   = (ramadr == PCMSK0_RAM_ADDR);
  assign pcmsk1_hit   = (ramadr == PCMSK1_RAM_ADDR);
  assign pcmsk2_hit   = (ramadr == PCMSK2_RAM_ADDR);
  assign pcmsk3_hit   = (ramadr == PCMSK3_RAM_ADDR);
  assign ram_hit      = pcicr_hit | pcmsk0_hit | pcmsk1_hit | pcmsk2_hit | pcmsk3_hit;

  // Mask vector as seen by the edge detector and by the port blocks.
  assign pcmsk = {pcmsk3_q, pcmsk2_q, 1'b0, pcmsk1_q, pcmsk0_q};
  assign pcie  = pcicr_q;

  // Edge detection. The mask is the registered value, so a mask write that
  // lands on the same edge as a change takes effect only in the next cycle.
  logic [27:0] change;
  logic [3:0]  flag_set;
  logic [3:0]  flag_clr;
  logic [3:0]  pcifr_next;

  assign change   = (sync2_q ^ hist_q) & pcmsk;
  assign flag_set = {|change[27:24], |change[23:16], |change[15:8], |change[7:0]};
  assign flag_clr = ((iowe && pcifr_io_hit) ? dbus_in[3:0] : 4'h0) | irq_ack;
  // Set has priority over clear, so an edge is never lost to a coincident clear.
  assign pcifr_next = (pcifr_q & ~flag_clr) | flag_set;

  // The flag and the enable are both registered, so irq appears in the same
  // cycle as the flag and drops as soon as either bit is cleared.
  assign irq = pcifr_q & pcicr_q;

  // NOTE: every state element is written with non-blocking assignments and
  // reset asynchronously, so the flops update in parallel and reset does not
  // wait for a clock edge.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      pcicr_q  <= '0;
      pcifr_q  <= '0;
      pcmsk0_q <= '0;
      pcmsk1_q <= '0;
      pcmsk2_q <= '0;
      pcmsk3_q <= '0;
    end else begin
      sync1_q <= pcint_pin;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      pcifr_q <= pcifr_next;

      if (ramwe) begin
        if (pcicr_hit)  pcicr_q  <= dbus_in[3:0];
        if (pcmsk0_hit) pcmsk0_q <= dbus_in;
        if (pcmsk1_hit) pcmsk1_q <= dbus_in[6:0];
        if (pcmsk2_hit) pcmsk2_q <= dbus_in;
        if (pcmsk3_hit) pcmsk3_q <= dbus_in[3:0];
      end
    end
  end

  // Read mux. It is combinational, so data is valid in the same cycle as the strobe.
  // NOTE: outputs get a default before the case, so no path through the block
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (iore && pcifr_io_hit) begin
      dbus_out = {4'h0, pcifr_q};
      out_en   = 1'b1;
    end else if (ramre && ram_hit) begin
      out_en = 1'b1;
      if (pcicr_hit)       dbus_out = {4'h0, pcicr_q};
      else if (pcmsk0_hit) dbus_out = pcmsk0_q;
      else if (pcmsk1_hit) dbus_out = {1'b0, pcmsk1_q};
      else if (pcmsk2_hit) dbus_out = pcmsk2_q;
      else                 dbus_out = {4'h0, pcmsk3_q};
    end
  end

endmodule

// File: doc/pcint_ctrl.md
Name: pcint_ctrl

Overview:
Pin-change interrupt controller for PCINT[27:0]. It consumes the pin-input values produced by the four port blocks (Port_E supplies PCINT[27:24]), synchronises them, detects edges on masked pins and sets the PCIF0..3 flags. It drives interrupt requests to the core. It holds PCICR, PCIFR and PCMSK0..3, and it feeds the per-pin mask and group-enable bits back to the port blocks for digital-input-enable override.

Parameters:
PCIFR_IO_ADDR, 6'h1B, I/O-space address of PCIFR
PCICR_RAM_ADDR, 8'h68, data-space address of PCICR
PCMSK0_RAM_ADDR, 8'h6B, data-space address of PCMSK0 (PCINT7:0)
PCMSK1_RAM_ADDR, 8'h6C, data-space address of PCMSK1 (PCINT14:8; bit7 unimplemented)
PCMSK2_RAM_ADDR, 8'h6D, data-space address of PCMSK2 (PCINT23:16)
PCMSK3_RAM_ADDR, 8'h73, data-space address of PCMSK3 (PCINT27:24; bits7:4 unimplemented)

Ports:
cp2  in  1  system clock, all state on rising edge
ireset  in  1  asynchronous active-low reset
IO_Addr  in  6  I/O-space address
iore  in  1  I/O read strobe
iowe  in  1  I/O write strobe
ramadr  in  8  data-space address, low byte
ramre  in  1  data-space read strobe
ramwe  in  1  data-space write strobe
dbus_in  in  8  write data
dbus_out  out  8  read data, 0 when not selected
out_en  out  1  high when this block drives dbus_out
pcint_pin  in  28  raw pin values from port DIE outputs (asynchronous)
pcmsk  out  28  concatenated PCMSK3..0 (unimplemented bits 0)
pcie  out  4  PCICR[3:0]
irq  out  4  interrupt request per group, to core
irq_ack  in  4  one-cycle vector-taken acknowledge per group

Behaviour:
- Reset (ireset=0, async): PCICR, PCIFR and PCMSK0..3 = 0. Sync stages and edge-history register are loaded with 0. dbus_out=0, out_en=0, irq=0, pcmsk=0, pcie=0.
- Sync: two flops per pin, s1 <= pcint_pin, s2 <= s1. History h <= s2 every cycle. change[i] = (s2[i]^h[i]) & pcmsk[i].
- Flag set: PCIFn <= 1 on the edge after any change[i] in group n (n = i/8). Latency is 3 rising edges from pin transition to PCIF visible, and irq asserts in the same cycle as the flag.
- Group 1 bit 15 and group 3 bits 31:28 do not exist. Unimplemented mask bits are held at 0, so they never flag.
- Flag clear:
  - CPU write of PCIFR with bit n = 1 clears PCIFn. Writing 0 has no effect.
  - irq_ack[n] = 1 clears PCIFn.
  - If a set and a clear occur in the same cycle, set wins and the flag stays 1.
- irq[n] = PCIFn & PCIEn (registered flag ANDed with registered enable). Clearing PCIEn drops irq next cycle without clearing PCIFn. PCIFn sets regardless of PCIEn.
- Masked-out pins never set flags. Enabling a mask bit while the pin is stable produces no flag, because h already tracks s2.
- Writes:
  - Take effect on the rising edge with iowe (PCIFR) or ramwe (others) and a matching address.
  - PCICR bits 7:4 are ignored and read 0.
  - PCIFR bits 7:4 read 0.
- Reads:
  - out_en = (iore & IO_Addr==PCIFR_IO_ADDR) | (ramre & ramadr matches any RAM register). Combinational.
  - dbus_out is the selected register value (combinational); 0 otherwise.
- Timing boundaries:
  - A mask write and a pin change in the same cycle: the new mask applies from the next cycle.
  - Reset mid-operation aborts everything; the first post-reset cycle sees h=0, so a pin already high will not flag until masked and changed.
- Wake: irq serves as the sleep wake source. No asynchronous path is provided.

Test Plan:
- Reset, then read PCICR, PCIFR, PCMSK0..3 -> all 0x00; irq=0; out_en=1 only during each read.
- PCMSK3=0x01, PCICR=0x08, toggle pcint_pin[24] 0->1 at cycle T -> PCIFR reads 0x08 and irq[3]=1 from cycle T+3; irq[3] does not assert earlier.
- With PCIF3 set, pin toggle coincident with PCIFR write 0x08 -> PCIF3 remains 1. A later write of 0x08 with no pin activity -> PCIF3=0 and irq[3]=0 next cycle.
- PCMSK0=0x00, toggle pcint_pin[7:0] -> no flag. Then PCMSK0=0x80, toggle pin 7 -> PCIFR=0x01. With PCICR=0 -> irq[0] stays 0 until PCICR=0x01 is written, then irq[0]=1.
- Write PCMSK1=0xFF and PCMSK3=0xFF -> read back 0x7F and 0x0F; pcmsk[15] and pcmsk[27:24]=4'hF; toggle pin 15 -> no flag.
- Set PCIF2, pulse irq_ack[2] -> PCIF2=0 next cycle. Assert ireset mid-toggle -> all registers 0 immediately, irq=0.
